// File: rtl/system_sysid_checker.sv
// Avalon-MM read master that fetches the system ID (word 0) and the build
// timestamp (word 1) from the sysid slave. It compares both words against the
// expected build and reports pass/fail. Each read has a timeout, and a timed-out
// sequence is retried a bounded number of times.
module system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1393886764,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [3:0]  retry_count,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdId   = 3'd1;
  localparam logic [2:0] StWaitId = 3'd2;
  localparam logic [2:0] StRdTs   = 3'd3;
  localparam logic [2:0] StWaitTs = 3'd4;
  localparam logic [2:0] StCheck  = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

  localparam bit          Lat1         = (READ_LATENCY != 0);
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);
  localparam logic [3:0]  MaxRetries   = 4'(MAX_RETRIES);

  logic [2:0]  state_q, state_d;
  logic        gap_q, gap_d;   // one idle cycle with avm_read low before a retry
  logic [15:0] tmo_q, tmo_d;
  logic [3:0]  retry_q, retry_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_mm_q, id_mm_d;
  logic        ts_mm_q, ts_mm_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;

  logic        in_rd;
  logic        in_wait;
  logic        accept;
  logic        resp;
  logic [16:0] tmo_inc;
  logic        limit_hit;

  assign in_rd     = ((state_q == StRdId) || (state_q == StRdTs)) && !gap_q;
  assign in_wait   = (state_q == StWaitId) || (state_q == StWaitTs);
  assign accept    = in_rd && read_q && !avm_waitrequest;
  assign resp      = in_wait && avm_readdatavalid;
  assign tmo_inc   = {1'b0, tmo_q} + 17'd1;
  assign limit_hit = (in_rd || in_wait) && (tmo_inc >= {1'b0, TimeoutLimit});

  // Next-state and registered-output computation for the read sequence.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    read_d    = read_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    id_mm_d   = id_mm_q;
    ts_mm_d   = ts_mm_q;
    timeout_d = timeout_q;
    id_d      = id_q;
    ts_d      = ts_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRdId;
          gap_d     = 1'b0;
          tmo_d     = '0;
          retry_d   = '0;
          read_d    = 1'b1;
          addr_d    = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          id_mm_d   = 1'b0;
          ts_mm_d   = 1'b0;
          timeout_d = 1'b0;
          id_d      = '0;
          ts_d      = '0;
        end
      end

      StRdId, StRdTs, StWaitId, StWaitTs: begin
        if (gap_q) begin
          gap_d  = 1'b0;
          read_d = 1'b1;
        end else begin
          tmo_d = tmo_inc[15:0];
          if ((accept && !Lat1) || resp) begin
            // Read completed: capture data and move to the next word.
            if ((state_q == StRdId) || (state_q == StWaitId)) begin
              id_d    = avm_readdata;
              state_d = StRdTs;
              read_d  = 1'b1;
              addr_d  = 1'b1;
              tmo_d   = '0;
            end else begin
              ts_d    = avm_readdata;
              state_d = StCheck;
              read_d  = 1'b0;
            end
          end else if (limit_hit) begin
            read_d = 1'b0;
            if (retry_q < MaxRetries) begin
              retry_d = retry_q + 4'd1;
              state_d = StRdId;
              addr_d  = 1'b0;
              gap_d   = 1'b1;
              tmo_d   = '0;
            end else begin
              timeout_d = 1'b1;
              state_d   = StDone;
              busy_d    = 1'b0;
              done_d    = 1'b1;
            end
          end else if (accept) begin
            // Latency-1 slave accepted the command; wait for readdatavalid.
            read_d  = 1'b0;
            state_d = (state_q == StRdId) ? StWaitId : StWaitTs;
          end
        end
      end

      StCheck: begin
        id_mm_d = (id_q != EXPECTED_ID);
        ts_mm_d = (ts_q != EXPECTED_TIMESTAMP);
        pass_d  = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP);
        state_d = StDone;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = StIdle;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      gap_q     <= 1'b0;
      tmo_q     <= '0;
      retry_q   <= '0;
      read_q    <= 1'b0;
      addr_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      id_mm_q   <= 1'b0;
      ts_mm_q   <= 1'b0;
      timeout_q <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      id_mm_q   <= id_mm_d;
      ts_mm_q   <= ts_mm_d;
      timeout_q <= timeout_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mm_q;
  assign ts_mismatch = ts_mm_q;
  assign timeout     = timeout_q;
  assign retry_count = retry_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule
